// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - ID/EX issue register driving ALU operands with EX/MEM and MEM/WB forwarding
module alu_issue #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic [4:0]      rs1_idx,
    input  logic [4:0]      rs2_idx,
    input  logic [4:0]      rd_idx,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    input  logic            out_ready,
    input  logic            exmem_we,
    input  logic [4:0]      exmem_rd,
    input  logic [XLEN-1:0] exmem_res,
    input  logic            memwb_we,
    input  logic [4:0]      memwb_rd,
    input  logic [XLEN-1:0] memwb_res,
    output logic            out_valid,
    output logic [XLEN-1:0] A,
    output logic [XLEN-1:0] B,
    output logic [3:0]      aluOp,
    output logic [4:0]      out_rd,
    output logic            out_illegal
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic            validQ;
    logic            illegalQ;
    logic [3:0]      aluOpQ;
    logic [4:0]      rdQ;
    logic            useRs1Q;
    logic            useRs2Q;
    logic [4:0]      rs1IdxQ;
    logic [4:0]      rs2IdxQ;
    logic [XLEN-1:0] aBaseQ;
    logic [XLEN-1:0] bBaseQ;

    logic            decUseRs1;
    logic            decUseRs2;
    logic [XLEN-1:0] decA;
    logic [XLEN-1:0] decB;
    logic [3:0]      decOp;
    logic            decIllegal;
    logic            accept;

    assign in_ready = !validQ || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        decUseRs1  = 1'b0;
        decUseRs2  = 1'b0;
        decA       = '0;
        decB       = '0;
        decOp      = 4'b0000;
        decIllegal = 1'b0;
        case (opcode)
            OP_R: begin
                decUseRs1 = 1'b1;
                decUseRs2 = 1'b1;
                decA      = rs1_data;
                decB      = rs2_data;
                decOp     = {funct7b5, funct3};
            end
            OP_I: begin
                decUseRs1 = 1'b1;
                decA      = rs1_data;
                decB      = imm;
                // funct7b5 only distinguishes SRAI; for other I-ops it is immediate bit 10
                decOp     = (funct3 == 3'b101) ? {funct7b5, funct3} : {1'b0, funct3};
            end
            OP_LOAD, OP_STORE: begin
                decUseRs1 = 1'b1;
                decA      = rs1_data;
                decB      = imm;
            end
            OP_BRANCH: begin
                decUseRs1 = 1'b1;
                decUseRs2 = 1'b1;
                decA      = rs1_data;
                decB      = rs2_data;
                decOp     = 4'b1000;
            end
            OP_LUI: begin
                decB = imm;
            end
            OP_AUIPC: begin
                decA = pc;
                decB = imm;
            end
            OP_JAL, OP_JALR: begin
                decA = pc;
                decB = XLEN'(4);
            end
            default: decIllegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            validQ   <= 1'b0;
            illegalQ <= 1'b0;
            aluOpQ   <= 4'b0000;
            rdQ      <= 5'd0;
            useRs1Q  <= 1'b0;
            useRs2Q  <= 1'b0;
            rs1IdxQ  <= 5'd0;
            rs2IdxQ  <= 5'd0;
            aBaseQ   <= '0;
            bBaseQ   <= '0;
        end else if (flush) begin
            validQ <= 1'b0;
        end else if (accept) begin
            validQ   <= 1'b1;
            illegalQ <= decIllegal;
            aluOpQ   <= decOp;
            rdQ      <= rd_idx;
            useRs1Q  <= decUseRs1;
            useRs2Q  <= decUseRs2;
            rs1IdxQ  <= rs1_idx;
            rs2IdxQ  <= rs2_idx;
            aBaseQ   <= decA;
            bBaseQ   <= decB;
        end else if (validQ && out_ready) begin
            validQ <= 1'b0;
        end
    end

    function automatic logic [XLEN-1:0] fwdSel(
        input logic [4:0]      idx,
        input logic [XLEN-1:0] rfVal,
        input logic            exWe,
        input logic [4:0]      exRd,
        input logic [XLEN-1:0] exRes,
        input logic            wbWe,
        input logic [4:0]      wbRd,
        input logic [XLEN-1:0] wbRes
    );
        if (idx != 5'd0 && exWe && exRd == idx) begin
            return exRes;
        end else if (idx != 5'd0 && wbWe && wbRd == idx) begin
            return wbRes;
        end
        return rfVal;
    endfunction

    // Forwarding stays combinational so a producer retiring during a stall is seen immediately
    always_comb begin
        A = useRs1Q ? fwdSel(rs1IdxQ, aBaseQ, exmem_we, exmem_rd, exmem_res,
                             memwb_we, memwb_rd, memwb_res) : aBaseQ;
        B = useRs2Q ? fwdSel(rs2IdxQ, bBaseQ, exmem_we, exmem_rd, exmem_res,
                             memwb_we, memwb_rd, memwb_res) : bBaseQ;
    end

    assign out_valid   = validQ;
    assign aluOp       = aluOpQ;
    assign out_rd      = rdQ;
    assign out_illegal = illegalQ;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - vector table, corner sequences and random model check for alu_issue
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rs1_idx, rs2_idx, rd_idx;
    logic [31:0] rs1_data, rs2_data, imm, pc;
    logic        flush;
    logic        out_ready;
    logic        exmem_we;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_res;
    logic        memwb_we;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_res;
    logic        out_valid;
    logic [31:0] A, B;
    logic [3:0]  aluOp;
    logic [4:0]  out_rd;
    logic        out_illegal;

    int checks = 0;
    int errors = 0;

    alu_issue #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rd_idx(rd_idx),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
        .flush(flush), .out_ready(out_ready),
        .exmem_we(exmem_we), .exmem_rd(exmem_rd), .exmem_res(exmem_res),
        .memwb_we(memwb_we), .memwb_rd(memwb_rd), .memwb_res(memwb_res),
        .out_valid(out_valid), .A(A), .B(B), .aluOp(aluOp),
        .out_rd(out_rd), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] r1d;
        logic [31:0] r2d;
        logic [31:0] immv;
        logic [31:0] pcv;
        logic [31:0] expA;
        logic [31:0] expB;
        logic [3:0]  expOp;
        logic        expIll;
    } vec_t;

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  r1, r2, rd;
        logic [31:0] r1d, r2d, immv, pcv;
    } instr_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] iv, input logic [31:0] p);
        opcode = o; funct3 = f3; funct7b5 = f7;
        rs1_idx = r1; rs2_idx = r2; rd_idx = rd;
        rs1_data = d1; rs2_data = d2; imm = iv; pc = p;
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] fw(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 0) return rf;
        if (exmem_we && exmem_rd == idx) return exmem_res;
        if (memwb_we && memwb_rd == idx) return memwb_res;
        return rf;
    endfunction

    task automatic refModel(input instr_t i, output logic [31:0] ea, output logic [31:0] eb,
                            output logic [3:0] eop, output logic eill);
        ea = 0; eb = 0; eop = 0; eill = 0;
        case (i.opc)
            7'b0110011: begin ea = fw(i.r1, i.r1d); eb = fw(i.r2, i.r2d); eop = {i.f7, i.f3}; end
            7'b0010011: begin
                ea = fw(i.r1, i.r1d); eb = i.immv;
                eop = (i.f3 == 3'd5) ? {i.f7, i.f3} : {1'b0, i.f3};
            end
            7'b0000011, 7'b0100011: begin ea = fw(i.r1, i.r1d); eb = i.immv; end
            7'b1100011: begin ea = fw(i.r1, i.r1d); eb = fw(i.r2, i.r2d); eop = 4'b1000; end
            7'b0110111: eb = i.immv;
            7'b0010111: begin ea = i.pcv; eb = i.immv; end
            7'b1101111, 7'b1100111: begin ea = i.pcv; eb = 32'd4; end
            default: eill = 1;
        endcase
    endtask

    logic [6:0] legalOps[9];
    instr_t cur, held;
    logic   heldValid;
    logic [31:0] ea, eb;
    logic [3:0]  eop;
    logic        eill;
    logic        nextValid;
    instr_t      nextHeld;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{7'b0110011, 3'd0, 1'b0, 32'd7, 32'd3, 32'h0, 32'h0, 32'd7, 32'd3, 4'b0000, 1'b0};
        vecs[1]  = '{7'b0110011, 3'd0, 1'b1, 32'd7, 32'd3, 32'h0, 32'h0, 32'd7, 32'd3, 4'b1000, 1'b0};
        vecs[2]  = '{7'b0010011, 3'd5, 1'b1, 32'h80, 32'h9, 32'h403, 32'h0, 32'h80, 32'h403, 4'b1101, 1'b0};
        vecs[3]  = '{7'b0010011, 3'd0, 1'b1, 32'h10, 32'h9, 32'h400, 32'h0, 32'h10, 32'h400, 4'b0000, 1'b0};
        vecs[4]  = '{7'b0010011, 3'd2, 1'b1, 32'h11, 32'h9, 32'hFFFFFC00, 32'h0, 32'h11, 32'hFFFFFC00, 4'b0010, 1'b0};
        vecs[5]  = '{7'b0110011, 3'd3, 1'b0, 32'h5, 32'h6, 32'h0, 32'h0, 32'h5, 32'h6, 4'b0011, 1'b0};
        vecs[6]  = '{7'b0000011, 3'd2, 1'b0, 32'h1000, 32'h6, 32'h20, 32'h0, 32'h1000, 32'h20, 4'b0000, 1'b0};
        vecs[7]  = '{7'b0100011, 3'd2, 1'b1, 32'h2000, 32'h6, 32'hFFFFFFF0, 32'h0, 32'h2000, 32'hFFFFFFF0, 4'b0000, 1'b0};
        vecs[8]  = '{7'b1100011, 3'd1, 1'b0, 32'h33, 32'h44, 32'h8, 32'h0, 32'h33, 32'h44, 4'b1000, 1'b0};
        vecs[9]  = '{7'b0110111, 3'd0, 1'b0, 32'h33, 32'h44, 32'h12345000, 32'h0, 32'h0, 32'h12345000, 4'b0000, 1'b0};
        vecs[10] = '{7'b0010111, 3'd0, 1'b0, 32'h33, 32'h44, 32'h1000, 32'h200, 32'h200, 32'h1000, 4'b0000, 1'b0};
        vecs[11] = '{7'b1101111, 3'd0, 1'b0, 32'h33, 32'h44, 32'h80, 32'h100, 32'h100, 32'h4, 4'b0000, 1'b0};
        vecs[12] = '{7'b1100111, 3'd0, 1'b1, 32'h33, 32'h44, 32'h80, 32'h300, 32'h300, 32'h4, 4'b0000, 1'b0};
        vecs[13] = '{7'b1111111, 3'd7, 1'b1, 32'h33, 32'h44, 32'h80, 32'h300, 32'h0, 32'h0, 4'b0000, 1'b1};
        legalOps = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                     7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};

        rst = 1; in_valid = 0; flush = 0; out_ready = 1;
        exmem_we = 0; exmem_rd = 0; exmem_res = 0;
        memwb_we = 0; memwb_rd = 0; memwb_res = 0;
        drive(7'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        tick; tick;
        rst = 0;
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_A", A, 32'd0);
        chk("reset_B", B, 32'd0);
        chk("reset_aluOp", {28'd0, aluOp}, 32'd0);
        chk("reset_illegal", {31'd0, out_illegal}, 32'd0);
        chk("reset_rd", {27'd0, out_rd}, 32'd0);

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].opc, vecs[i].f3, vecs[i].f7, 5'd1, 5'd2, 5'(i + 3),
                  vecs[i].r1d, vecs[i].r2d, vecs[i].immv, vecs[i].pcv);
            in_valid = 1;
            tick;
            in_valid = 0;
            #1;
            chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("vec%0d_A", i), A, vecs[i].expA);
            chk($sformatf("vec%0d_B", i), B, vecs[i].expB);
            chk($sformatf("vec%0d_aluOp", i), {28'd0, aluOp}, {28'd0, vecs[i].expOp});
            chk($sformatf("vec%0d_illegal", i), {31'd0, out_illegal}, {31'd0, vecs[i].expIll});
            chk($sformatf("vec%0d_rd", i), {27'd0, out_rd}, 32'(i + 3));
        end
        tick;

        // Back-pressure: X held three cycles while Y waits, then Y follows exactly once
        drive(7'b0110011, 3'd0, 1'b0, 5'd1, 5'd2, 5'd9, 32'd11, 32'd22, 32'd0, 32'd0);
        in_valid = 1;
        tick;
        out_ready = 0;
        drive(7'b0110011, 3'd0, 1'b0, 5'd1, 5'd2, 5'd10, 32'd33, 32'd44, 32'd0, 32'd0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_A", A, 32'd11);
            chk("stall_B", B, 32'd22);
            tick;
        end
        out_ready = 1;
        #1;
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("release_A_still_X", A, 32'd11);
        tick;
        in_valid = 0;
        #1;
        chk("next_valid", {31'd0, out_valid}, 32'd1);
        chk("next_A", A, 32'd33);
        chk("next_rd", {27'd0, out_rd}, 32'd10);
        tick;
        #1;
        chk("no_duplicate", {31'd0, out_valid}, 32'd0);

        // Forwarding priority and live update during a stall
        drive(7'b0110011, 3'd0, 1'b0, 5'd5, 5'd6, 5'd1, 32'h1234, 32'h5678, 32'd0, 32'd0);
        in_valid = 1; out_ready = 0;
        tick;
        in_valid = 0;
        exmem_we = 1; exmem_rd = 5; exmem_res = 32'hAAAA;
        memwb_we = 1; memwb_rd = 5; memwb_res = 32'hBBBB;
        #1 chk("fwd_exmem", A, 32'hAAAA);
        chk("fwd_B_unaffected", B, 32'h5678);
        exmem_we = 0;
        #1 chk("fwd_memwb", A, 32'hBBBB);
        memwb_we = 0;
        #1 chk("fwd_none", A, 32'h1234);
        out_ready = 1;
        tick;
        drive(7'b0110011, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 32'h5555, 32'h6666, 32'd0, 32'd0);
        exmem_we = 1; exmem_rd = 0; memwb_we = 1; memwb_rd = 0;
        in_valid = 1;
        tick;
        in_valid = 0;
        #1 chk("fwd_x0_A", A, 32'h5555);
        chk("fwd_x0_B", B, 32'h6666);
        exmem_we = 0; memwb_we = 0;
        tick;

        // Flush beats a simultaneous accept, and also kills a held instruction
        in_valid = 1; flush = 1;
        tick;
        in_valid = 0; flush = 0;
        #1 chk("flush_accept", {31'd0, out_valid}, 32'd0);
        in_valid = 1; out_ready = 0;
        tick;
        in_valid = 0; flush = 1;
        tick;
        flush = 0;
        #1 chk("flush_held", {31'd0, out_valid}, 32'd0);
        out_ready = 1;

        // Reset in the middle of a stall
        drive(7'b0010111, 3'd0, 1'b0, 5'd1, 5'd2, 5'd7, 32'd1, 32'd2, 32'h8, 32'h40);
        in_valid = 1; out_ready = 0;
        tick;
        in_valid = 0;
        #1 chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        rst = 1;
        tick;
        rst = 0;
        #1;
        chk("rst_stall_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_stall_A", A, 32'd0);
        chk("rst_stall_B", B, 32'd0);
        chk("rst_stall_aluOp", {28'd0, aluOp}, 32'd0);
        chk("rst_stall_rd", {27'd0, out_rd}, 32'd0);
        chk("rst_stall_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1;

        // Randomized run against the reference model
        heldValid = 0;
        held = '{default: '0};
        for (int n = 0; n < 3000; n++) begin
            cur.opc  = ($urandom_range(0, 15) == 0) ? 7'($urandom) : legalOps[$urandom_range(0, 8)];
            cur.f3   = 3'($urandom); cur.f7 = 1'($urandom);
            cur.r1   = 5'($urandom_range(0, 3)); cur.r2 = 5'($urandom_range(0, 3));
            cur.rd   = 5'($urandom);
            cur.r1d  = $urandom; cur.r2d = $urandom; cur.immv = $urandom; cur.pcv = $urandom;
            drive(cur.opc, cur.f3, cur.f7, cur.r1, cur.r2, cur.rd, cur.r1d, cur.r2d, cur.immv, cur.pcv);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            exmem_we  = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3)); exmem_res = $urandom;
            memwb_we  = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3)); memwb_res = $urandom;
            @(negedge clk);
            chk("rnd_valid", {31'd0, out_valid}, {31'd0, heldValid});
            chk("rnd_in_ready", {31'd0, in_ready}, {31'd0, !heldValid || out_ready});
            if (heldValid) begin
                refModel(held, ea, eb, eop, eill);
                chk("rnd_A", A, ea);
                chk("rnd_B", B, eb);
                chk("rnd_aluOp", {28'd0, aluOp}, {28'd0, eop});
                chk("rnd_illegal", {31'd0, out_illegal}, {31'd0, eill});
                chk("rnd_rd", {27'd0, out_rd}, {27'd0, held.rd});
            end
            nextValid = heldValid;
            nextHeld  = held;
            if (rst) begin
                nextValid = 0;
                nextHeld  = '{default: '0};
            end else if (flush) begin
                nextValid = 0;
            end else if (in_valid && (!heldValid || out_ready)) begin
                nextValid = 1;
                nextHeld  = cur;
            end else if (heldValid && out_ready) begin
                nextValid = 0;
            end
            @(posedge clk);
            #2;
            heldValid = nextValid;
            held      = nextHeld;
        end
        rst = 0; flush = 0; in_valid = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

ID/EX issue stage for the pipelined core: a one-entry register between decode and execute. It accepts a decoded RV32I instruction with valid/ready, registers it, and drives the ALU's `A`, `B` and 4-bit `aluOp` inputs. The 4-bit opcode is derived from opcode/funct3/funct7[5]. Operands are resolved through EX/MEM and MEM/WB forwarding. It is the producing end of the ALU operand interface (`A`, `B`, `aluOp` → `aluRes`).

## Interface
- `XLEN`, 32, datapath width.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  decode presents an instruction.
- `in_ready`  out  1  stage can accept this cycle.
- `opcode`  in  7  RV32I major opcode.
- `funct3`  in  3  instruction funct3.
- `funct7b5`  in  1  instruction bit 30.
- `rs1_idx`, `rs2_idx`, `rd_idx`  in  5 each  register indices.
- `rs1_data`, `rs2_data`  in  XLEN  register-file read data.
- `imm`  in  XLEN  sign-extended immediate.
- `pc`  in  XLEN  instruction address.
- `flush`  in  1  kill the held instruction (branch mispredict).
- `out_ready`  in  1  EX/MEM can accept.
- `exmem_we`, `exmem_rd`, `exmem_res`  in  1/5/XLEN  EX/MEM forward source.
- `memwb_we`, `memwb_rd`, `memwb_res`  in  1/5/XLEN  MEM/WB forward source.
- `out_valid`  out  1  held instruction valid.
- `A`, `B`  out  XLEN  ALU operands.
- `aluOp`  out  4  ALU operation.
- `out_rd`  out  5  destination index, passed through.
- `out_illegal`  out  1  held opcode unsupported.

## Operation
- aluOp encoding is {bit3, funct3}:
  - 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND.
- Decode table. Selection is registered on accept; forwarding is applied on the output side.
  - R-type (0110011): A=rs1, B=rs2, aluOp={funct7b5,funct3}.
  - I-ALU (0010011): A=rs1, B=imm. aluOp={funct7b5,funct3} only when funct3=101; otherwise {0,funct3}. So ADDI with imm[10]=1 is ADD, never SUB.
  - Load (0000011) / store (0100011): A=rs1, B=imm, 0000.
  - Branch (1100011): A=rs1, B=rs2, 1000.
  - LUI (0110111): A=0, B=imm, 0000.
  - AUIPC (0010111): A=pc, B=imm, 0000.
  - JAL (1101111) / JALR (1100111): A=pc, B=4, 0000.
  - Any other opcode: out_illegal=1, A=0, B=0, aluOp 0000.
- Forwarding applies only where the operand source is rs1/rs2. Sources are checked in priority order:
  - EX/MEM, when exmem_we and exmem_rd==idx and idx≠0.
  - Else MEM/WB, under the same rule.
  - Else the registered rf data.
  - x0 is never forwarded.
- Handshake: `in_ready = !out_valid || out_ready`. Accept occurs when in_valid && in_ready.
- State update per cycle, in priority order:
  - rst: out_valid=0, all registered fields=0.
  - flush: out_valid=0; any input offered that cycle is dropped and in_ready is ignored.
  - accept: load the fields; out_valid=1.
  - out_valid && out_ready without accept: out_valid=0.
  - stall (out_valid && !out_ready): hold every register.

## Timing
- Reset values: out_valid=0, out_illegal=0, aluOp=0000, A=0, B=0, out_rd=0. in_ready=1 from the first cycle after reset.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 instruction/cycle while out_ready=1.
- A and B are combinational from registered state plus the forward inputs. A forward-source change during a stall updates A/B in the same cycle.
- Simultaneous flush and accept: the flush wins and out_valid=0 next cycle.
- rst overrides flush and every handshake.

## Test plan
- Reset, then R-type ADD with rs1=7, rs2=3, funct7b5=0 → one cycle later out_valid=1, A=7, B=3, aluOp=0000.
- Same instruction with funct7b5=1 → aluOp=1000 (SUB). SRAI with funct7b5=1 → 1101. ADDI with funct7b5=1 → 0000.
- Hold out_ready=0 for 3 cycles with a new in_valid offered → in_ready=0 and outputs stable. Release → next instruction appears exactly one cycle later, no loss or duplicate.
- rs1_idx=5; exmem_we=1, exmem_rd=5, exmem_res=0xAAAA; memwb_we=1, memwb_rd=5, memwb_res=0xBBBB → A=0xAAAA. Clear exmem_we → A=0xBBBB. rs1_idx=0 with both forwards matching rd=0 → A=rs1_data.
- Assert flush together with an in_valid accept → out_valid=0 next cycle. Assert rst mid-stall → all outputs at reset values next cycle.
- JAL with pc=0x100 → A=0x100, B=4, aluOp=0000. Opcode 1111111 → out_illegal=1, A=B=0.
